// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
//   Shared types and helpers for the parametrised modulo counter.
//   - cnt_mode_t  : wrap-around versus saturate-at-boundary behaviour
//   - clamp_load(): limits a load value to the counter's terminal value
// -----------------------------------------------------------------------------
package mod_counter_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_t;

   // Widest counter the arithmetic below is written for.
   localparam int unsigned MAX_SUPPORTED_WIDTH = 32;

   // Values above the terminal value are pulled down to it, so a load can
   // never place the counter outside 0..max_val.
   function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                              input logic [31:0] max_val);
      return (value > max_val) ? max_val : value;
   endfunction

endpackage : mod_counter_pkg

// File: rtl/mod_counter_props.sv
// -----------------------------------------------------------------------------
// mod_counter_props
//   Property checker for mod_counter_gen, compiled only for formal runs.
//   Every port is an input mirroring the counter's own ports.
//   Ports:
//     clk, rst                 clock and asynchronous active-high reset
//     en, up, load, clr        control inputs of the counter
//     load_val [WIDTH]         load value seen by the counter
//     count [WIDTH]            counter state
//     tc, ovf, at_max, at_min  counter status outputs
// -----------------------------------------------------------------------------
`ifdef FORMAL
module mod_counter_props
   import mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 6,
   parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
   parameter int unsigned STEP      = 1,
   parameter bit          SATURATE  = 1'b0,
   parameter int unsigned RESET_VAL = 0
) (
   input logic             clk,
   input logic             rst,
   input logic             en,
   input logic             up,
   input logic             load,
   input logic [WIDTH-1:0] load_val,
   input logic             clr,
   input logic [WIDTH-1:0] count,
   input logic             tc,
   input logic             ovf,
   input logic             at_max,
   input logic             at_min
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

   // Set one edge after reset release, so $past() only looks at
   // post-reset cycles.
   logic f_past_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_past_valid <= 1'b0;
      end else begin
         f_past_valid <= 1'b1;
      end
   end

   a_range : assert property (@(posedge clk) disable iff (rst)
      count <= MAX_W);

   a_tc_ovf : assert property (@(posedge clk) disable iff (rst)
      tc |-> ovf);

   a_flags : assert property (@(posedge clk) disable iff (rst)
      (at_max == (count == MAX_W)) && (at_min == (count == '0)));

   a_clr : assert property (@(posedge clk) disable iff (rst)
      (f_past_valid && $past(clr)) |-> ((count == RST_W) && !ovf));

   a_load : assert property (@(posedge clk) disable iff (rst)
      (f_past_valid && $past(load && !clr))
         |-> (count == WIDTH'(clamp_load(32'($past(load_val)), 32'(MAX_VAL)))));

   c_tc_pulse : cover property (@(posedge clk) disable iff (rst)
      f_past_valid && !tc ##1 tc ##1 !tc);

   if (SATURATE) begin : g_cov_sat
      c_saturate : cover property (@(posedge clk) disable iff (rst)
         f_past_valid && tc && $past(en && up) && (count == MAX_W) && ($past(count) == MAX_W));
   end else begin : g_cov_wrap
      c_wrap_up : cover property (@(posedge clk) disable iff (rst)
         f_past_valid && tc && $past(en && up && !load && !clr) && (count < $past(count)));
      c_wrap_dn : cover property (@(posedge clk) disable iff (rst)
         f_past_valid && tc && $past(en && !up && !load && !clr) && (count > $past(count)));
   end

   // STEP only shapes behaviour through the counter itself.
   localparam int unsigned UNUSED_STEP = STEP;

endmodule : mod_counter_props
`endif

// File: rtl/mod_counter_gen.sv
// -----------------------------------------------------------------------------
// mod_counter_gen
//   Parametrised modulo up/down counter.
//   - Configurable width, terminal value and step size.
//   - Wraps modulo (MAX_VAL+1) or saturates at the boundary.
//   - Per-edge priority: clr > load > en.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous reset, active-high
//     en        in   count enable
//     up        in   direction, 1 = up, 0 = down (used only while en=1)
//     load      in   synchronous load of load_val (clamped to MAX_VAL)
//     load_val  in   [WIDTH] load value
//     clr       in   synchronous clear to RESET_VAL, also clears ovf
//     count     out  [WIDTH] current count, registered
//     tc        out  one-cycle pulse: a boundary event happened on the last edge
//     ovf       out  sticky boundary-event flag
//     at_max    out  count == MAX_VAL
//     at_min    out  count == 0
// -----------------------------------------------------------------------------
module mod_counter_gen
   import mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 6,
   parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
   parameter int unsigned STEP      = 1,
   parameter bit          SATURATE  = 1'b0,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             at_max,
   output logic             at_min
);

   // ---------------------------------------------------------------------
   // Parameter sanity checks, evaluated at elaboration
   // ---------------------------------------------------------------------
   if (WIDTH < 1 || WIDTH > MAX_SUPPORTED_WIDTH) begin : g_err_width
      $error("mod_counter_gen: WIDTH must be in 1..32");
   end
   if (MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_err_max
      $error("mod_counter_gen: MAX_VAL must be in 1..2**WIDTH-1");
   end
   if (STEP < 1 || STEP > MAX_VAL) begin : g_err_step
      $error("mod_counter_gen: STEP must be in 1..MAX_VAL");
   end
   if (RESET_VAL > MAX_VAL) begin : g_err_reset
      $error("mod_counter_gen: RESET_VAL must not exceed MAX_VAL");
   end

   localparam cnt_mode_t MODE = SATURATE ? CNT_SAT : CNT_WRAP;

   // One extra bit keeps count+STEP exact even when MAX_VAL = 2**WIDTH-1.
   localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX_VAL);
   localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH:0]   MOD_X  = MAX_X + 1'b1;
   localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q,    tc_d;
   logic             ovf_q,   ovf_d;
   logic [WIDTH:0]   cnt_x;
   logic             up_evt;
   logic             dn_evt;

   assign cnt_x  = {1'b0, count_q};
   assign up_evt = cnt_x > (MAX_X - STEP_X);
   assign dn_evt = cnt_x < STEP_X;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q;

      if (clr) begin
         // A clear suppresses any boundary event that en would have caused.
         count_d = RST_W;
         ovf_d   = 1'b0;
      end else if (load) begin
         count_d = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));
      end else if (en) begin
         if (up) begin
            if (up_evt) begin
               tc_d    = 1'b1;
               ovf_d   = 1'b1;
               count_d = (MODE == CNT_SAT) ? MAX_W : WIDTH'(cnt_x + STEP_X - MOD_X);
            end else begin
               count_d = WIDTH'(cnt_x + STEP_X);
            end
         end else begin
            if (dn_evt) begin
               tc_d    = 1'b1;
               ovf_d   = 1'b1;
               count_d = (MODE == CNT_SAT) ? '0 : WIDTH'(cnt_x + MOD_X - STEP_X);
            end else begin
               count_d = WIDTH'(cnt_x - STEP_X);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RST_W;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count  = count_q;
   assign tc     = tc_q;
   assign ovf    = ovf_q;
   assign at_max = (count_q == MAX_W);
   assign at_min = (count_q == '0);

`ifdef FORMAL
   mod_counter_props #(
      .WIDTH     (WIDTH),
      .MAX_VAL   (MAX_VAL),
      .STEP      (STEP),
      .SATURATE  (SATURATE),
      .RESET_VAL (RESET_VAL)
   ) u_props (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .clr      (clr),
      .count    (count_q),
      .tc       (tc_q),
      .ovf      (ovf_q),
      .at_max   (at_max),
      .at_min   (at_min)
   );
`endif

endmodule : mod_counter_gen

// File: tb/tb_mod_counter_gen.sv
// -----------------------------------------------------------------------------
// tb_mod_counter_gen
//   Three counters (wrap/STEP=1, saturate/STEP=1, wrap/STEP=7 with
//   RESET_VAL=5), all MAX_VAL=39, driven by shared stimulus and compared
//   against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mod_counter_gen;

   localparam int W    = 6;
   localparam int MAXV = 39;
   localparam int ND   = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         en, up, load, clr;
   logic [W-1:0] load_val;

   logic [W-1:0] count_w  [ND];
   logic         tc_w     [ND];
   logic         ovf_w    [ND];
   logic         at_max_w [ND];
   logic         at_min_w [ND];

   int step_p [ND] = '{1, 1, 7};
   bit sat_p  [ND] = '{1'b0, 1'b1, 1'b0};
   int rv_p   [ND] = '{0, 0, 5};

   int m_cnt [ND];
   bit m_tc  [ND];
   bit m_ovf [ND];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mod_counter_gen #(.WIDTH(6), .MAX_VAL(39), .STEP(1), .SATURATE(1'b0), .RESET_VAL(0)) u_dut_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .clr(clr),
      .count(count_w[0]), .tc(tc_w[0]), .ovf(ovf_w[0]), .at_max(at_max_w[0]), .at_min(at_min_w[0]));

   mod_counter_gen #(.WIDTH(6), .MAX_VAL(39), .STEP(1), .SATURATE(1'b1), .RESET_VAL(0)) u_dut_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .clr(clr),
      .count(count_w[1]), .tc(tc_w[1]), .ovf(ovf_w[1]), .at_max(at_max_w[1]), .at_min(at_min_w[1]));

   mod_counter_gen #(.WIDTH(6), .MAX_VAL(39), .STEP(7), .SATURATE(1'b0), .RESET_VAL(5)) u_dut_step (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .clr(clr),
      .count(count_w[2]), .tc(tc_w[2]), .ovf(ovf_w[2]), .at_max(at_max_w[2]), .at_min(at_min_w[2]));

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int k = 0; k < ND; k++) begin
         m_cnt[k] = rv_p[k];
         m_tc[k]  = 1'b0;
         m_ovf[k] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < ND; k++) begin
         if (clr) begin
            m_cnt[k] = rv_p[k];
            m_tc[k]  = 1'b0;
            m_ovf[k] = 1'b0;
         end else if (load) begin
            m_cnt[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
            m_tc[k]  = 1'b0;
         end else if (en) begin
            int s;
            s = up ? m_cnt[k] + step_p[k] : m_cnt[k] - step_p[k];
            if (s > MAXV || s < 0) begin
               m_tc[k]  = 1'b1;
               m_ovf[k] = 1'b1;
               if (sat_p[k]) s = (s < 0) ? 0 : MAXV;
               else          s = (s + MAXV + 1) % (MAXV + 1);
            end else begin
               m_tc[k] = 1'b0;
            end
            m_cnt[k] = s;
         end else begin
            m_tc[k] = 1'b0;
         end
      end
   endtask

   task automatic drive(input bit e, input bit u, input bit l, input bit c, input int lv);
      en       = e;
      up       = u;
      load     = l;
      clr      = c;
      load_val = W'(lv);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      #12;
      model_reset();
      for (int k = 0; k < ND; k++) begin
         n_checks++;
         if (count_w[k] !== W'(rv_p[k]) || tc_w[k] !== 1'b0 || ovf_w[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: count=%0d tc=%b ovf=%b, required count=%0d tc=0 ovf=0",
                     k, count_w[k], tc_w[k], ovf_w[k], rv_p[k]);
         end
      end
      n_checks++;
      if (at_min_w[0] !== 1'b1 || at_max_w[0] !== 1'b0 || at_min_w[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: at_min0=%b at_max0=%b at_min2=%b, required 1 0 0",
                  at_min_w[0], at_max_w[0], at_min_w[2]);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      n_checks++;
      if (count_w[0] !== 6'd0 || count_w[2] !== 6'd5 || tc_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: count0=%0d count2=%0d tc0=%b, required 0 5 0", count_w[0], count_w[2], tc_w[0]);
      end
      $display("test_reset: count0=%0d count2=%0d", count_w[0], count_w[2]);
   endtask

   task automatic test_wrap_count();
      drive(1, 1, 0, 0, 0);
      for (int i = 1; i <= 40; i++) begin
         tick();
         $display("wrap_count edge %0d: count0=%0d tc0=%b count1=%0d count2=%0d", i, count_w[0], tc_w[0], count_w[1], count_w[2]);
         n_checks++;
         if (count_w[0] !== W'(i % 40) || tc_w[0] !== (i == 40)) begin
            n_fail++;
            $display("FAIL wrap_up edge %0d: count=%0d tc=%b, required count=%0d tc=%b", i, count_w[0], tc_w[0], i % 40, (i == 40));
         end
         for (int k = 1; k < ND; k++) begin
            n_checks++;
            if (count_w[k] !== W'(m_cnt[k]) || tc_w[k] !== m_tc[k]) begin
               n_fail++;
               $display("FAIL wrap_up_model dut%0d edge %0d: count=%0d tc=%b, required %0d %b", k, i, count_w[k], tc_w[k], m_cnt[k], m_tc[k]);
            end
         end
      end
      n_checks++;
      if (ovf_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_up_ovf: ovf=%b, required 1", ovf_w[0]);
      end
   endtask

   task automatic test_load_down();
      int exp_seq [6] = '{4, 3, 2, 1, 0, 39};
      drive(0, 0, 1, 0, 5);
      tick();
      n_checks++;
      if (count_w[0] !== 6'd5 || tc_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL load5: count=%0d tc=%b, required 5 0", count_w[0], tc_w[0]);
      end
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         $display("load_down edge %0d: count0=%0d tc0=%b count2=%0d", i, count_w[0], tc_w[0], count_w[2]);
         n_checks++;
         if (count_w[0] !== W'(exp_seq[i]) || tc_w[0] !== (i == 5)) begin
            n_fail++;
            $display("FAIL down edge %0d: count=%0d tc=%b, required %0d %b", i, count_w[0], tc_w[0], exp_seq[i], (i == 5));
         end
         n_checks++;
         if (count_w[2] !== W'(m_cnt[2]) || tc_w[2] !== m_tc[2]) begin
            n_fail++;
            $display("FAIL down_step7 edge %0d: count=%0d tc=%b, required %0d %b", i, count_w[2], tc_w[2], m_cnt[2], m_tc[2]);
         end
      end
   endtask

   task automatic test_saturate();
      drive(0, 0, 1, 0, 38);
      tick();
      drive(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         $display("saturate edge %0d: count1=%0d tc1=%b", i, count_w[1], tc_w[1]);
         n_checks++;
         if (count_w[1] !== 6'd39 || tc_w[1] !== (i >= 1) || ovf_w[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold edge %0d: count=%0d tc=%b ovf=%b, required 39 %b 1", i, count_w[1], tc_w[1], ovf_w[1], (i >= 1));
         end
      end
      drive(0, 0, 0, 1, 0);
      tick();
      $display("saturate clr: count1=%0d ovf1=%b", count_w[1], ovf_w[1]);
      n_checks++;
      if (count_w[1] !== 6'd0 || ovf_w[1] !== 1'b0 || tc_w[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_clr: count=%0d ovf=%b tc=%b, required 0 0 0", count_w[1], ovf_w[1], tc_w[1]);
      end
   endtask

   task automatic test_clamp();
      drive(0, 0, 1, 0, 63);
      tick();
      $display("clamp: count0=%0d at_max0=%b", count_w[0], at_max_w[0]);
      n_checks++;
      if (count_w[0] !== 6'd39 || at_max_w[0] !== 1'b1 || at_min_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL clamp: count=%0d at_max=%b at_min=%b, required 39 1 0", count_w[0], at_max_w[0], at_min_w[0]);
      end
      // clr beats load and a would-be boundary event on the same edge
      drive(1, 1, 1, 1, 63);
      tick();
      $display("clr_priority: count0=%0d count2=%0d", count_w[0], count_w[2]);
      n_checks++;
      if (count_w[0] !== 6'd0 || tc_w[0] !== 1'b0 || ovf_w[0] !== 1'b0 || count_w[2] !== 6'd5) begin
         n_fail++;
         $display("FAIL clr_priority: count0=%0d tc0=%b ovf0=%b count2=%0d, required 0 0 0 5",
                  count_w[0], tc_w[0], ovf_w[0], count_w[2]);
      end
   endtask

   task automatic test_step();
      drive(0, 0, 1, 0, 35);
      tick();
      drive(1, 1, 0, 0, 0);
      tick();
      $display("step up: count2=%0d tc2=%b", count_w[2], tc_w[2]);
      n_checks++;
      if (count_w[2] !== 6'd2 || tc_w[2] !== 1'b1 || ovf_w[2] !== 1'b1 || count_w[0] !== 6'd36) begin
         n_fail++;
         $display("FAIL step_wrap_up: count2=%0d tc2=%b ovf2=%b count0=%0d, required 2 1 1 36",
                  count_w[2], tc_w[2], ovf_w[2], count_w[0]);
      end
      drive(1, 0, 0, 0, 0);
      tick();
      $display("step down: count2=%0d tc2=%b", count_w[2], tc_w[2]);
      n_checks++;
      if (count_w[2] !== 6'd35 || tc_w[2] !== 1'b1 || count_w[0] !== 6'd35) begin
         n_fail++;
         $display("FAIL step_wrap_down: count2=%0d tc2=%b count0=%0d, required 35 1 35", count_w[2], tc_w[2], count_w[0]);
      end
      drive(0, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (tc_w[2] !== 1'b0 || count_w[2] !== 6'd35 || ovf_w[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL tc_one_cycle: tc2=%b count2=%0d ovf2=%b, required 0 35 1", tc_w[2], count_w[2], ovf_w[2]);
      end
   endtask

   task automatic test_async_reset();
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 0) begin
            drive(0, 0, 1, 0, 20);
            tick();
         end else begin
            drive(0, 0, 1, 0, 39);
            tick();
            drive(1, 1, 0, 0, 0);
            tick();
            n_checks++;
            if (tc_w[0] !== 1'b1 || ovf_w[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL pre_reset_event: tc0=%b ovf0=%b, required 1 1", tc_w[0], ovf_w[0]);
            end
         end
         drive(0, 0, 0, 0, 0);
         #2;
         rst = 1'b1;
         #1;
         model_reset();
         $display("async_reset phase %0d: count0=%0d tc0=%b ovf0=%b", ph, count_w[0], tc_w[0], ovf_w[0]);
         for (int k = 0; k < ND; k++) begin
            n_checks++;
            if (count_w[k] !== W'(rv_p[k]) || tc_w[k] !== 1'b0 || ovf_w[k] !== 1'b0) begin
               n_fail++;
               $display("FAIL async_reset ph%0d dut%0d: count=%0d tc=%b ovf=%b, required %0d 0 0",
                        ph, k, count_w[k], tc_w[k], ovf_w[k], rv_p[k]);
            end
         end
         @(negedge clk);
         rst = 1'b0;
      end
      drive(1, 1, 0, 0, 0);
      tick();
      n_checks++;
      if (count_w[0] !== 6'd1 || count_w[2] !== 6'd12) begin
         n_fail++;
         $display("FAIL first_edge_after_reset: count0=%0d count2=%0d, required 1 12", count_w[0], count_w[2]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
               int'($urandom_range(0, 63)));
         tick();
         $display("random %0d: en=%b up=%b ld=%b clr=%b lv=%0d -> counts %0d %0d %0d tc %b%b%b",
                  i, en, up, load, clr, load_val, count_w[0], count_w[1], count_w[2], tc_w[0], tc_w[1], tc_w[2]);
         for (int k = 0; k < ND; k++) begin
            n_checks++;
            if (count_w[k] !== W'(m_cnt[k]) || tc_w[k] !== m_tc[k] || ovf_w[k] !== m_ovf[k] ||
                at_max_w[k] !== (m_cnt[k] == MAXV) || at_min_w[k] !== (m_cnt[k] == 0)) begin
               n_fail++;
               $display("FAIL random %0d dut%0d: count=%0d tc=%b ovf=%b at_max=%b at_min=%b, required %0d %b %b %b %b",
                        i, k, count_w[k], tc_w[k], ovf_w[k], at_max_w[k], at_min_w[k],
                        m_cnt[k], m_tc[k], m_ovf[k], (m_cnt[k] == MAXV), (m_cnt[k] == 0));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrap_count();
      test_load_down();
      test_saturate();
      test_clamp();
      test_step();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mod_counter_gen
